// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle; holds the pipeline through stallreq for W+1 cycles.
module ex_muldiv #(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    input  logic [2:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         flush,
    output logic         stallreq,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   acc, acc_step;
    logic [W-1:0]     opnd;
    logic             sa, sb, is_div;
    logic             is_muldiv, is_mthi, is_mtlo, sgn_op, start, last;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum, div_trial;

    always_comb begin
        is_muldiv = op_valid && (op[2] == 1'b0);
        is_mthi   = op_valid && (op == 3'b100);
        is_mtlo   = op_valid && (op == 3'b101);
        sgn_op    = ~op[0];
        mag_a     = (sgn_op && src_a[W-1]) ? -src_a : src_a;
        mag_b     = (sgn_op && src_b[W-1]) ? -src_b : src_b;
        last      = (cnt == CNT_W'(W - 1));
        // acc holds {partial product} for multiply, {remainder, quotient} for divide
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, {W{acc[0]}} & opnd};
        div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, opnd};
        if (is_div) begin
            if (!div_trial[W])
                acc_step = {div_trial[W-1:0], acc[W-2:0], 1'b1};
            else
                acc_step = {acc[2*W-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[W-1:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        start     = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (is_muldiv) begin
                    stallreq  = 1'b1;
                    start     = 1'b1;
                    state_nxt = (op[1] && src_b == '0) ? DONE : RUN;
                end
                RUN: begin
                    stallreq = 1'b1;
                    if (last) state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        if (rst) stallreq = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            acc         <= '0;
            opnd        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            is_div      <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else if (state == IDLE) begin
                if (start) begin
                    cnt    <= '0;
                    sa     <= sgn_op & src_a[W-1];
                    sb     <= sgn_op & src_b[W-1];
                    is_div <= op[1];
                    if (op[1]) begin
                        acc         <= {{W{1'b0}}, mag_a};
                        opnd        <= mag_b;
                        div_by_zero <= (src_b == '0);
                    end else begin
                        acc  <= {{W{1'b0}}, mag_b};
                        opnd <= mag_a;
                    end
                end else if (is_mthi) begin
                    hi <= src_a;
                end else if (is_mtlo) begin
                    lo <= src_a;
                end
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + CNT_W'(1);
                // Sign correction only at write-back so HI/LO never see partial results
                if (last) begin
                    if (is_div) begin
                        lo <= (sa ^ sb) ? -acc_step[W-1:0] : acc_step[W-1:0];
                        hi <= sa ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
                    end else begin
                        {hi, lo} <= (sa ^ sb) ? -acc_step : acc_step;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (W=32 and W=8 instances).
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        stallreq, busy, div_by_zero;
    logic [31:0] hi, lo;

    logic        op_valid8 = 1'b0;
    logic [2:0]  op8 = 3'b000;
    logic [7:0]  src_a8 = '0;
    logic [7:0]  src_b8 = '0;
    logic        flush8 = 1'b0;
    logic        stallreq8, busy8, div_by_zero8;
    logic [7:0]  hi8, lo8;

    int total = 0;
    int bad   = 0;
    int stalls;

    always #5 clk = ~clk;

    ex_muldiv #(.W(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .stallreq(stallreq), .busy(busy), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    ex_muldiv #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .op_valid(op_valid8), .op(op8),
        .src_a(src_a8), .src_b(src_b8), .flush(flush8),
        .stallreq(stallreq8), .busy(busy8), .hi(hi8), .lo(lo8),
        .div_by_zero(div_by_zero8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns in DONE (first cycle with stallreq low)
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        n = 0;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stallreq) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic end_op();
        op_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_stall", stallreq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b000, 32'hFFFF_FFFD, 32'd5, stalls);
        chk("mult_stalls", stalls, 33);
        chk("mult_busy_done", busy, 1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        end_op();
        chk("mult_idle", busy, 0);

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls);
        chk("multu_stalls", stalls, 33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        end_op();

        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, stalls);
        chk("mult_min_hi", hi, 32'h4000_0000);
        chk("mult_min_lo", lo, 32'h0);
        end_op();

        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, stalls);
        chk("div_stalls", stalls, 33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        end_op();

        run_op(3'b011, 32'd7, 32'd2, stalls);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        end_op();

        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, stalls);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);
        end_op();

        op_valid = 1'b1; op = 3'b100; src_a = 32'h1234;
        #1 chk("mthi_stall", stallreq, 0);
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", busy, 0);
        op = 3'b101; src_a = 32'h5678;
        #1 chk("mtlo_stall", stallreq, 0);
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_hi_kept", hi, 32'h1234);
        op_valid = 1'b0;
        @(negedge clk);

        run_op(3'b011, 32'd9, 32'd0, stalls);
        chk("dbz_stalls", stalls, 1);
        chk("dbz_pulse", div_by_zero, 1);
        chk("dbz_hi", hi, 32'h1234);
        chk("dbz_lo", lo, 32'h5678);
        end_op();
        chk("dbz_pulse_end", div_by_zero, 0);
        chk("dbz_idle", busy, 0);

        op_valid = 1'b1; op = 3'b110; src_a = 32'hAAAA; src_b = 32'h3;
        #1 chk("unk_stall", stallreq, 0);
        @(negedge clk);
        chk("unk_busy", busy, 0);
        chk("unk_hi", hi, 32'h1234);
        op_valid = 1'b0;

        op_valid = 1'b1; op = 3'b100; src_a = 32'hDEAD; flush = 1'b1;
        @(negedge clk);
        chk("flush_mthi_hi", hi, 32'h1234);
        op_valid = 1'b0; flush = 1'b0;
        @(negedge clk);

        op_valid = 1'b1; op = 3'b001; src_a = 32'hFFFF; src_b = 32'hFFFF;
        #1 chk("flush_c0_stall", stallreq, 1);
        repeat (10) @(negedge clk);
        #1 chk("flush_run_stall", stallreq, 1);
        flush = 1'b1; op_valid = 1'b0;
        #1 chk("flush_stall", stallreq, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h5678);
        @(negedge clk);
        run_op(3'b001, 32'd3, 32'd4, stalls);
        chk("post_flush_stalls", stalls, 33);
        chk("post_flush_lo", lo, 32'd12);
        chk("post_flush_hi", hi, 32'd0);
        end_op();

        op_valid = 1'b1; op = 3'b010; src_a = 32'd100; src_b = 32'd7;
        repeat (5) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_busy", busy, 0);
        chk("arst_stall", stallreq, 0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        stalls = 0;
        op_valid8 = 1'b1; op8 = 3'b000; src_a8 = 8'h80; src_b8 = 8'hFF;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!stallreq8) break;
            stalls++;
            @(negedge clk);
        end
        chk("w8_stalls", stalls, 9);
        chk("w8_hi", hi8, 8'h00);
        chk("w8_lo", lo8, 8'h80);
        op_valid8 = 1'b0;
        @(negedge clk);
        chk("w8_idle", busy8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
